pixel_upsampler: RTL and testbench
==================================

Name: pixel_upsampler

Overview:
- Streaming 2x2 nearest-neighbour upsampler; inverse direction of the network's 2x2 average-pooling stage.
- Accepts a 14x14 pooled image as a raster-order pixel stream and emits a 28x28 raster stream, every source pixel replicated into a 2x2 block.
- Sits between the pooled-feature buffer and the display/readback path, so the reduced image can be shown at native 28x28 scale.
- One-row line buffer; each input row fills, then emits as two identical output lines.

Parameters:
- resolution, 8, bits per pixel.
- in_side, 14, input image side in pixels; output side is 2*in_side.
- col_w, $clog2(2*in_side), width of output x/y indices (5 at default).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_pixel  in  resolution  input pixel, raster order, row 0 col 0 first.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts output pixel.
- out_pixel  out  resolution  output pixel.
- out_x  out  col_w  output column 0..2*in_side-1.
- out_y  out  col_w  output row 0..2*in_side-1.
- out_sof  out  1  first pixel of frame (x=0,y=0), qualified by out_valid.
- out_eol  out  1  last pixel of an output line.
- out_eof  out  1  last pixel of frame.
- frame_done  out  1  one-cycle pulse the cycle after the last output transfer.

Behaviour:
- Transfer occurs on a rising clk edge when valid&ready are both high on that side.
- Reset (reset=0, asynchronous): state=FILL, all counters 0, in_ready=1, out_valid=0, frame_done=0. Line-buffer contents need no reset. Assertion mid-frame discards the partial frame; the first post-reset input is treated as row 0 col 0.
- State FILL:
  - in_ready=1, out_valid=0.
  - Each input transfer writes buf[in_col]=in_pixel and increments in_col.
  - The transfer with in_col==in_side-1 clears in_col and moves to EMIT.
  - Gaps in in_valid simply stall.
- State EMIT:
  - in_ready=0, so in_valid is ignored.
  - out_valid=1.
  - out_pixel=buf[out_col>>1], out_x=out_col, out_y=2*row+dup.
  - On each output transfer, out_col increments.
  - At out_col==2*in_side-1, out_col wraps to 0 and dup toggles.
  - When dup was 1 at that wrap: row increments and state returns to FILL.
  - If row was also in_side-1, row wraps to 0 and frame_done pulses next cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_pixel, out_x, out_y and all flags hold stable.
- Flags are combinational from counters:
  - out_sof = (row==0 && dup==0 && out_col==0).
  - out_eol = (out_col==2*in_side-1).
  - out_eof = out_eol && dup==1 && row==in_side-1.
- Latency and throughput:
  - First output is valid the cycle after the 14th input transfer of a row.
  - Per row: 14 input transfers, then 56 output transfers at one per cycle with out_ready=1. No input/output overlap.
  - Frame: 196 inputs in, 784 outputs out.
- Back-to-back frames: after frame_done, row=0 and state=FILL; the next input starts the next frame with no extra idle cycle.
- Widths: out_y computed at col_w bits, no overflow for in_side<=2^(col_w-1).

Decomposition:
- Shared package nn_pkg:
  - RESOLUTION=8, POOL_SIDE=14, IMG_SIDE=28.
  - FSM encoding FILL=1'b0, EMIT=1'b1.
  - Shared with the pooling stage so the image dimensions come from one source.
- One natural sub-module: pixel_line_buffer, an in_side x resolution register array with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- Counters and the FSM stay in pixel_upsampler.

Test Plan:
- Single frame, pattern in_pixel=(r*14+c)&8'hFF, out_ready=1 -> 784 outputs. Each (y,x) carries (y>>1)*14+(x>>1); e.g. (0,1)=0, (1,27)=13, (27,27)=195. out_sof only on the first output, out_eof only on the last, out_eol 28 times. frame_done pulses once.
- Random out_ready (50%) -> identical output sequence; out_pixel/out_x/out_y held stable through every stall cycle; in_ready=0 throughout EMIT.
- in_valid toggled 1/0, and in_valid held high during EMIT -> only 14 writes per row. First out_valid occurs exactly one cycle after the 14th accepted input.
- reset pulsed low mid-EMIT at row 5, out_col 10 -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. A fresh frame then produces correct output from out_sof.
- Two back-to-back frames (second pattern 8'hFF - value) -> in_ready=1 the cycle after frame_done. The second frame's outputs are correct, and no stale first-frame pixels appear.
- Row-boundary check: row 0 all 8'hAA, row 1 all 8'h55 -> output lines 0-1 all 8'hAA, lines 2-3 all 8'h55, and no 8'h55 appears in line 1.

Source files
------------

// File: rtl/nn_pkg.sv
// Purpose: image geometry shared by the pooling and upsampling stages, plus upsampler state encoding.
// Latency: none; constants and types only.
// Backpressure: not applicable.
package nn_pkg;

    localparam int RESOLUTION = 8;   // bits per pixel
    localparam int POOL_SIDE  = 14;  // pooled image side
    localparam int IMG_SIDE   = 28;  // native image side

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } up_state_t;

endpackage

// File: rtl/pixel_line_buffer.sv
// Purpose: one image row of pixel storage, written by column index and read combinationally.
// Latency: write visible to the read port the cycle after we; read is zero-latency.
// Backpressure: none; the owner sequences reads and writes.
//
// Ports:
//   clk          write clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata  combinational read port
module pixel_line_buffer #(
    parameter int RESOLUTION = 8,
    parameter int DEPTH      = 14,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [RESOLUTION-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [RESOLUTION-1:0] rdata
);

    // Contents are fully rewritten before every read, so no reset is needed.
    logic [RESOLUTION-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_upsampler.sv
// Purpose: streaming 2x2 nearest-neighbour upsampler, in_side^2 raster in -> (2*in_side)^2 raster out.
// Latency: first output of a row is valid the cycle after that row's last input transfer.
// Backpressure: in_ready low while a row is being emitted; outputs hold stable while out_ready is low.
//
// Ports:
//   clk, reset                      clock, async active-low reset
//   in_valid/in_ready/in_pixel      raster-order input stream
//   out_valid/out_ready/out_pixel   raster-order output stream
//   out_x/out_y                     output pixel coordinates
//   out_sof/out_eol/out_eof         frame/line markers, qualified by out_valid
//   frame_done                      pulse the cycle after the last output transfer
module pixel_upsampler
    import nn_pkg::*;
#(
    parameter int resolution = RESOLUTION,
    parameter int in_side    = POOL_SIDE,
    parameter int col_w      = $clog2(2 * in_side)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [resolution-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [resolution-1:0] out_pixel,
    output logic [col_w-1:0]      out_x,
    output logic [col_w-1:0]      out_y,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  frame_done
);

    localparam int IN_W = $clog2(in_side);
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(in_side - 1);
    localparam logic [col_w-1:0] OUT_LAST = col_w'(2 * in_side - 1);

    up_state_t         state_q, state_d;
    logic [IN_W-1:0]   in_col_q;
    logic [IN_W-1:0]   row_q;
    logic [col_w-1:0]  out_col_q;
    logic              dup_q;
    logic              frame_done_q;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == EMIT);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Flags are pure functions of the counters, so they hold through a stall.
    assign out_sof = (row_q == '0) && !dup_q && (out_col_q == '0);
    assign out_eol = (out_col_q == OUT_LAST);
    assign out_eof = out_eol && dup_q && (row_q == IN_LAST);

    assign out_x      = out_col_q;
    assign out_y      = col_w'({row_q, dup_q});  // 2*row + dup
    assign frame_done = frame_done_q;

    pixel_line_buffer #(
        .RESOLUTION (resolution),
        .DEPTH      (in_side),
        .AW         (IN_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (in_xfer),
        .waddr (in_col_q),
        .wdata (in_pixel),
        .raddr (IN_W'(out_col_q >> 1)),
        .rdata (out_pixel)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_xfer && (in_col_q == IN_LAST)) state_d = EMIT;
            EMIT:    if (out_xfer && out_eol && dup_q)     state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            in_col_q     <= '0;
            out_col_q    <= '0;
            dup_q        <= 1'b0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= out_xfer && out_eof;

            if (in_xfer) begin
                in_col_q <= (in_col_q == IN_LAST) ? '0 : in_col_q + 1'b1;
            end

            if (out_xfer) begin
                if (out_eol) begin
                    out_col_q <= '0;
                    dup_q     <= ~dup_q;
                    // Second copy of the line done: advance to the next source row.
                    if (dup_q) begin
                        row_q <= (row_q == IN_LAST) ? '0 : row_q + 1'b1;
                    end
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_upsampler.sv
// Purpose: self-checking bench for pixel_upsampler against a queue-based replication model.
// Latency: model expects a row's outputs the cycle after its last accepted input.
// Backpressure: random and constant out_ready; in_valid gaps and held-high during emit.
`timescale 1ns/1ps
module tb_pixel_upsampler;

    localparam int SIDE  = 14;
    localparam int OSIDE = 28;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic [4:0] out_x;
    logic [4:0] out_y;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic       frame_done;

    always #5 clk = ~clk;

    pixel_upsampler dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done)
    );

    typedef struct {
        int pix;
        int x;
        int y;
        bit sof;
        bit eol;
        bit eof;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_cur;
    exp_t        t_new;
    int          in_row[$];
    int          row_cnt = 0;
    bit          fd_exp = 0;
    bit          stall_prev = 0;
    logic [20:0] held;
    int          sof_n = 0, eol_n = 0, eof_n = 0;
    int          fd_count = 0;
    int          test_id = 0;
    bit          rand_ready = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [7:0] pat(input int kind, input int r, input int c);
        logic [7:0] v;
        v = 8'((r * SIDE + c) & 255);
        case (kind)
            1:       return 8'hFF - v;
            2:       return (r == 0) ? 8'hAA : ((r == 1) ? 8'h55 : v);
            default: return v;
        endcase
    endfunction

    // Model + compare: every source row, once complete, becomes two identical
    // output lines of 2*SIDE pixels, each source pixel repeated twice.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            in_row.delete();
            row_cnt    = 0;
            fd_exp     = 0;
            stall_prev = 0;
            sof_n = 0; eol_n = 0; eof_n = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_hold", int'({out_pixel, out_x, out_y, out_sof, out_eol, out_eof}), int'(held));
            end
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("in_ready", int'(in_ready), int'(exp_q.size() == 0));
            chk("frame_done", int'(frame_done), int'(fd_exp));
            if (frame_done) begin
                fd_count++;
                chk("sof_per_frame", sof_n, 1);
                chk("eol_per_frame", eol_n, OSIDE);
                chk("eof_per_frame", eof_n, 1);
                chk("ready_after_done", int'(in_ready), 1);
                sof_n = 0; eol_n = 0; eof_n = 0;
            end
            fd_exp = 0;

            if (out_valid && out_ready && exp_q.size() != 0) begin
                e_cur = exp_q.pop_front();
                chk("out_pixel", int'(out_pixel), e_cur.pix);
                chk("out_x", int'(out_x), e_cur.x);
                chk("out_y", int'(out_y), e_cur.y);
                chk("out_sof", int'(out_sof), int'(e_cur.sof));
                chk("out_eol", int'(out_eol), int'(e_cur.eol));
                chk("out_eof", int'(out_eof), int'(e_cur.eof));
                sof_n += int'(out_sof);
                eol_n += int'(out_eol);
                eof_n += int'(out_eof);
                if (e_cur.eof) fd_exp = 1;
                if (test_id == 1) begin
                    if (e_cur.y == 0 && e_cur.x == 1)   chk("pin_y0_x1", int'(out_pixel), 0);
                    if (e_cur.y == 1 && e_cur.x == 27)  chk("pin_y1_x27", int'(out_pixel), 13);
                    if (e_cur.y == 27 && e_cur.x == 27) chk("pin_y27_x27", int'(out_pixel), 195);
                end
                if (test_id == 6) begin
                    if (e_cur.y <= 1)      chk("rowb_line01", int'(out_pixel), 8'hAA);
                    else if (e_cur.y <= 3) chk("rowb_line23", int'(out_pixel), 8'h55);
                end
            end

            if (in_valid && in_ready) begin
                in_row.push_back(int'(in_pixel));
                if (in_row.size() == SIDE) begin
                    for (int d = 0; d < 2; d++) begin
                        for (int x = 0; x < OSIDE; x++) begin
                            t_new.pix = in_row[x / 2];
                            t_new.x   = x;
                            t_new.y   = 2 * row_cnt + d;
                            t_new.sof = (row_cnt == 0) && (d == 0) && (x == 0);
                            t_new.eol = (x == OSIDE - 1);
                            t_new.eof = (x == OSIDE - 1) && (d == 1) && (row_cnt == SIDE - 1);
                            exp_q.push_back(t_new);
                        end
                    end
                    row_cnt = (row_cnt + 1) % SIDE;
                    in_row.delete();
                end
            end

            stall_prev = out_valid && !out_ready;
            held       = {out_pixel, out_x, out_y, out_sof, out_eol, out_eof};
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_pixel(input logic [7:0] p, input bit gap);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_pixel = p;
        @(negedge clk);
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int kind, input int nrows, input bit gap, input bit release_end);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < SIDE; c++) begin
                send_pixel(pat(kind, r, c), gap);
            end
        end
        if (release_end) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (out_valid) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_base;
        int n;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: single frame, continuous ready
        test_id = 1;
        fd_base = fd_count;
        send_frame(0, SIDE, 1'b0, 1'b1);
        wait_idle();
        chk("t1_frames", fd_count - fd_base, 1);

        // 2: random backpressure
        test_id    = 2;
        rand_ready = 1'b1;
        fd_base    = fd_count;
        send_frame(0, SIDE, 1'b0, 1'b1);
        wait_idle();
        rand_ready = 1'b0;
        chk("t2_frames", fd_count - fd_base, 1);

        // 3: in_valid gaps; in_valid stays high while the row is emitted
        test_id = 3;
        fd_base = fd_count;
        send_frame(0, SIDE, 1'b1, 1'b1);
        wait_idle();
        chk("t3_frames", fd_count - fd_base, 1);

        // 4: reset mid-emit at row 5, column 10, then a fresh frame
        test_id = 4;
        send_frame(0, 6, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_y == 5'd10 && out_x == 5'd10) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_row5_col10", int'(out_valid && out_y == 5'd10 && out_x == 5'd10), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_async_out_valid", int'(out_valid), 0);
        chk("t4_async_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        fd_base = fd_count;
        send_frame(1, SIDE, 1'b0, 1'b1);
        wait_idle();
        chk("t4_frames", fd_count - fd_base, 1);

        // 5: two back-to-back frames with no idle between them
        test_id = 5;
        fd_base = fd_count;
        send_frame(0, SIDE, 1'b0, 1'b0);
        send_frame(1, SIDE, 1'b0, 1'b1);
        wait_idle();
        chk("t5_frames", fd_count - fd_base, 2);

        // 6: row boundary, row 0 = AA, row 1 = 55
        test_id = 6;
        fd_base = fd_count;
        send_frame(2, SIDE, 1'b0, 1'b1);
        wait_idle();
        chk("t6_frames", fd_count - fd_base, 1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
